dmem_port_arbiter: RTL

- Shares the single-port data memory between two masters: requester 0 is the pipelined CPU's MEM stage; requester 1 is the loader/debug master that preloads or inspects data memory.
- Sequences each word access with a fixed memory latency and returns read data to the winner.
- Raises a CPU stall while a CPU access is pending.
- Sits between the CPU MEM stage and the data memory.

---
 rtl/dmem_port_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-master arbiter for the single-port data memory (CPU MEM stage vs loader/debug).
// Optional round-robin arbitration: define DMEM_ARB_ROUND_ROBIN_EN.
module dmem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int MEM_BYTES = 128,
    parameter int MEM_LAT   = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              r0_req_i,
    input  logic              r0_we_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [31:0]       r0_wdata_i,
    output logic [31:0]       r0_rdata_o,
    output logic              r0_done_o,
    input  logic              r1_req_i,
    input  logic              r1_we_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [31:0]       r1_wdata_i,
    output logic [31:0]       r1_rdata_o,
    output logic              r1_done_o,
    output logic              err_o,
    output logic              stall_o,
    output logic              mem_en_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    // Highest legal word address, compared at full address width.
    localparam logic [ADDR_W-1:0] LP_MAX_ADDR = ADDR_W'(MEM_BYTES - 4);
    localparam logic [2:0]        LP_LAT      = 3'(MEM_LAT);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [2:0]        r_cnt;
    logic              r_gnt;
    logic              r_we;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;

    logic              w_any;
    logic              w_gnt;
    logic              w_grant;
    logic              w_legal;
    logic              w_last_cnt;
    logic              w_done;
    logic [ADDR_W-1:0] w_addr;

    assign w_any      = r0_req_i | r1_req_i;
    assign w_grant    = (r_state == S_IDLE) && w_any;
    assign w_last_cnt = (r_cnt == LP_LAT);
    assign w_addr     = w_gnt ? r1_addr_i : r0_addr_i;
    assign w_legal    = (w_addr[1:0] == 2'b00) && (w_addr <= LP_MAX_ADDR);

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic r_last;

    // On a tie, grant the requester that did not win last time.
    always_comb begin
        if (r0_req_i && r1_req_i) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = ~r0_req_i;
        end
    end

    // Remember every winner, legal address or not.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last <= 1'b1;
        end else if (w_grant) begin
            r_last <= w_gnt;
        end
    end
`else
    // Fixed priority: the CPU always wins a tie.
    always_comb begin
        w_gnt = ~r0_req_i;
    end
`endif

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; illegal addresses skip the memory entirely.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_state_nxt = w_legal ? S_WAIT : S_DONE;
                end
            end
            S_WAIT: begin
                if (w_last_cnt) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the winning request at grant and capture load data at the end of WAIT.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt   <= '0;
            r_gnt   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_grant) begin
            r_cnt   <= 3'd1;
            r_gnt   <= w_gnt;
            r_we    <= w_gnt ? r1_we_i : r0_we_i;
            r_err   <= ~w_legal;
            r_addr  <= w_addr;
            r_wdata <= w_gnt ? r1_wdata_i : r0_wdata_i;
            r_rdata <= '0;
        end else if (r_state == S_WAIT) begin
            if (w_last_cnt) begin
                if (!r_we) begin
                    r_rdata <= mem_rdata_i;
                end
            end else begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign w_done      = (r_state == S_DONE);
    assign r0_done_o   = w_done & ~r_gnt;
    assign r1_done_o   = w_done & r_gnt;
    assign r0_rdata_o  = r0_done_o ? r_rdata : 32'd0;
    assign r1_rdata_o  = r1_done_o ? r_rdata : 32'd0;
    assign err_o       = w_done & r_err;
    assign mem_en_o    = (r_state == S_WAIT) && (r_cnt == 3'd1);
    assign mem_we_o    = mem_en_o & r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
    assign stall_o     = r0_req_i & ~r0_done_o & ~rst_i;

endmodule
